// File: rtl/sift_ctrl_pkg.sv
// Shared types and helpers for the SIFT keypoint control path.
package sift_ctrl_pkg;

  localparam int unsigned TAG_W_DEF = 20;
  localparam int unsigned COORD_W   = 10;

  typedef struct packed {
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x;
  } kp_tag_t;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_FLUSH     = 2'd1,
    ST_DONE      = 2'd2,
    ST_DONE_WAIT = 2'd3
  } ctrl_state_e;

  // Ceiling log2 for sizing selects and counters; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/kp_result_fifo.sv
// Synchronous result FIFO with occupancy count; head data is presented
// directly from storage (no write-to-read bypass).
module kp_result_fifo
  import sift_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 23,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   iclk,
  input  logic                   irst_n,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   valid_o,
  output logic [clog2(DEPTH):0]  count_o
);

  localparam int unsigned AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign rdata_o = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push_i && !do_pop)      count_q <= count_q + (AW+1)'(1);
      else if (!push_i && do_pop) count_q <= count_q - (AW+1)'(1);
    end
  end

  // Upstream credit accounting must make a push into a full FIFO impossible.
  assert property (@(posedge iclk) disable iff (!irst_n)
    !(push_i && !do_pop && (count_q == (AW+1)'(DEPTH))));

endmodule

// File: rtl/kp_contrast_scheduler.sv
// Round-robin scheduler sharing one low-contrast datapath among NREQ scale layers,
// with tag pipe, credit-protected result FIFO and frame flush. Option: KP_CONTRAST_STATS_EN.
module kp_contrast_scheduler
  import sift_ctrl_pkg::*;
#(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned TAG_W      = TAG_W_DEF,
  parameter int unsigned CALC_LAT   = 3,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                    iclk,
  input  logic                    irst_n,
  input  logic [NREQ-1:0]         ireq_valid,
  output logic [NREQ-1:0]         oreq_ready,
  input  logic [NREQ*TAG_W-1:0]   ireq_tag,
  output logic                    ocalc_start,
  output logic [clog2(NREQ)-1:0]  ocalc_sel,
  output logic [TAG_W-1:0]        ocalc_tag,
  input  logic                    icalc_lowcontrast_en,
  output logic                    okp_valid,
  input  logic                    ikp_ready,
  output logic [TAG_W-1:0]        okp_tag,
  output logic [clog2(NREQ)-1:0]  okp_src,
  output logic                    okp_keep,
  input  logic                    iflush,
  output logic                    oflush_done,
  output logic                    obusy
`ifdef KP_CONTRAST_STATS_EN
  ,
  output logic [15:0]             okept_cnt,
  output logic [15:0]             orej_cnt
`endif
);

  localparam int unsigned SEL_W = clog2(NREQ);
  localparam int unsigned CNT_W = clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned ENT_W = SEL_W + TAG_W + 1;

  ctrl_state_e      state_q, state_d;
  logic             run_en;
  logic             flush_done_d;
  logic             flush_done_q;
  logic             busy_q;

  logic [SEL_W-1:0] rr_q;
  logic             gnt_vld;
  logic [SEL_W-1:0] gnt_idx;
  int unsigned      cand;
  logic             credit_ok;
  logic             grant;

  logic             calc_start_q;
  logic [SEL_W-1:0] calc_sel_q;
  logic [TAG_W-1:0] calc_tag_q;

  logic             pipe_vld_q [CALC_LAT];
  logic [SEL_W-1:0] pipe_src_q [CALC_LAT];
  logic [TAG_W-1:0] pipe_tag_q [CALC_LAT];
  logic             pipe_out;

  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] fifo_cnt, fifo_cnt_d;
  logic             pop;
  logic [ENT_W-1:0] push_data;
  logic [ENT_W-1:0] head_data;

  // First valid requester at or after the round-robin pointer, wrapping.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = 32'(rr_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!gnt_vld && ireq_valid[SEL_W'(cand)]) begin
        gnt_vld = 1'b1;
        gnt_idx = SEL_W'(cand);
      end
    end
  end

  // Credits cover everything issued but not yet popped downstream.
  assign credit_ok = (SUM_W'(inflight_q) + SUM_W'(fifo_cnt)) < SUM_W'(FIFO_DEPTH);
  assign grant     = gnt_vld && credit_ok && run_en;

  always_comb begin
    oreq_ready = '0;
    if (grant) oreq_ready[gnt_idx] = 1'b1;
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      calc_start_q <= 1'b0;
      calc_sel_q   <= '0;
      calc_tag_q   <= '0;
      rr_q         <= '0;
    end else begin
      calc_start_q <= grant;
      if (grant) begin
        calc_sel_q <= gnt_idx;
        calc_tag_q <= ireq_tag[32'(gnt_idx)*TAG_W +: TAG_W];
        rr_q       <= (32'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + SEL_W'(1);
      end
    end
  end

  // Issue registers act as stage 0; the last stage lines up with the datapath result.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      for (int s = 0; s < int'(CALC_LAT); s++) begin
        pipe_vld_q[s] <= 1'b0;
        pipe_src_q[s] <= '0;
        pipe_tag_q[s] <= '0;
      end
    end else begin
      pipe_vld_q[0] <= calc_start_q;
      pipe_src_q[0] <= calc_sel_q;
      pipe_tag_q[0] <= calc_tag_q;
      for (int s = 1; s < int'(CALC_LAT); s++) begin
        pipe_vld_q[s] <= pipe_vld_q[s-1];
        pipe_src_q[s] <= pipe_src_q[s-1];
        pipe_tag_q[s] <= pipe_tag_q[s-1];
      end
    end
  end

  assign pipe_out  = pipe_vld_q[CALC_LAT-1];
  assign push_data = {pipe_src_q[CALC_LAT-1], pipe_tag_q[CALC_LAT-1], ~icalc_lowcontrast_en};
  assign pop       = okp_valid && ikp_ready;

  always_comb begin
    inflight_d = inflight_q;
    fifo_cnt_d = fifo_cnt;
    if (grant && !pipe_out)      inflight_d = inflight_q + CNT_W'(1);
    else if (!grant && pipe_out) inflight_d = inflight_q - CNT_W'(1);
    if (pipe_out && !pop)        fifo_cnt_d = fifo_cnt + CNT_W'(1);
    else if (!pipe_out && pop)   fifo_cnt_d = fifo_cnt - CNT_W'(1);
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      inflight_q   <= '0;
      busy_q       <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      inflight_q   <= inflight_d;
      busy_q       <= (inflight_d != '0) || (fifo_cnt_d != '0);
      flush_done_q <= flush_done_d;
    end
  end

  kp_result_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .iclk    (iclk),
    .irst_n  (irst_n),
    .push_i  (pipe_out),
    .wdata_i (push_data),
    .pop_i   (pop),
    .rdata_o (head_data),
    .valid_o (okp_valid),
    .count_o (fifo_cnt)
  );

  assign {okp_src, okp_tag, okp_keep} = head_data;

  // Flush control: state register.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) state_q <= ST_RUN;
    else         state_q <= state_d;
  end

  // Flush control: next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:       if (iflush) state_d = ST_FLUSH;
      ST_FLUSH:     if ((inflight_q == '0) && (fifo_cnt == '0)) state_d = ST_DONE;
      ST_DONE:      state_d = iflush ? ST_DONE_WAIT : ST_RUN;
      ST_DONE_WAIT: if (!iflush) state_d = ST_RUN;
      default:      state_d = ST_RUN;
    endcase
  end

  // Flush control: outputs. DONE lasts a single cycle, so entry marks the pulse.
  always_comb begin
    run_en       = (state_q == ST_RUN);
    flush_done_d = (state_d == ST_DONE);
  end

  assign ocalc_start = calc_start_q;
  assign ocalc_sel   = calc_sel_q;
  assign ocalc_tag   = calc_tag_q;
  assign oflush_done = flush_done_q;
  assign obusy       = busy_q;

`ifdef KP_CONTRAST_STATS_EN
  logic [15:0] kept_q;
  logic [15:0] rej_q;

  // Saturating per-frame pass/reject counts of FIFO pushes.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      kept_q <= '0;
      rej_q  <= '0;
    end else if (flush_done_d) begin
      kept_q <= '0;
      rej_q  <= '0;
    end else if (pipe_out) begin
      if (!icalc_lowcontrast_en && (kept_q != 16'hFFFF)) kept_q <= kept_q + 16'd1;
      if (icalc_lowcontrast_en && (rej_q != 16'hFFFF))   rej_q  <= rej_q + 16'd1;
    end
  end

  assign okept_cnt = kept_q;
  assign orej_cnt  = rej_q;
`endif

endmodule

// File: tb/tb_kp_contrast_scheduler.sv
// Randomized scoreboard bench for kp_contrast_scheduler against a transaction-level model.
`timescale 1ns/1ps
module tb_kp_contrast_scheduler;

  localparam int NREQ   = 4;
  localparam int TAG_W  = 20;
  localparam int SEL_W  = 2;
  localparam int FDEPTH = 8;
  localparam int LAT    = 3;
  localparam int M_RUN = 0, M_FLUSH = 1, M_DONE = 2, M_WAIT = 3;

  logic                   iclk = 1'b0;
  logic                   irst_n;
  logic [NREQ-1:0]        ireq_valid;
  logic [NREQ-1:0]        oreq_ready;
  logic [NREQ*TAG_W-1:0]  ireq_tag;
  logic                   ocalc_start;
  logic [SEL_W-1:0]       ocalc_sel;
  logic [TAG_W-1:0]       ocalc_tag;
  logic                   icalc_lowcontrast_en;
  logic                   okp_valid;
  logic                   ikp_ready;
  logic [TAG_W-1:0]       okp_tag;
  logic [SEL_W-1:0]       okp_src;
  logic                   okp_keep;
  logic                   iflush;
  logic                   oflush_done;
  logic                   obusy;
`ifdef KP_CONTRAST_STATS_EN
  logic [15:0]            okept_cnt;
  logic [15:0]            orej_cnt;
`endif

  always #5 iclk = ~iclk;

  kp_contrast_scheduler #(
    .NREQ(NREQ), .TAG_W(TAG_W), .CALC_LAT(LAT), .FIFO_DEPTH(FDEPTH)
  ) dut (
    .iclk(iclk), .irst_n(irst_n),
    .ireq_valid(ireq_valid), .oreq_ready(oreq_ready), .ireq_tag(ireq_tag),
    .ocalc_start(ocalc_start), .ocalc_sel(ocalc_sel), .ocalc_tag(ocalc_tag),
    .icalc_lowcontrast_en(icalc_lowcontrast_en),
    .okp_valid(okp_valid), .ikp_ready(ikp_ready), .okp_tag(okp_tag),
    .okp_src(okp_src), .okp_keep(okp_keep),
    .iflush(iflush), .oflush_done(oflush_done), .obusy(obusy)
`ifdef KP_CONTRAST_STATS_EN
    , .okept_cnt(okept_cnt), .orej_cnt(orej_cnt)
`endif
  );

  typedef struct { int src; logic [TAG_W-1:0] tag; } iss_t;
  typedef struct { int src; logic [TAG_W-1:0] tag; bit keep; } res_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  iss_t iss_q[$];
  res_t res_q[$];
  int   pend[$];           // cycle at which each outstanding result may reach the head
  bit   lc_sched[int];     // datapath answer to drive in a given cycle
  bit   lc_force[$];       // forced answers for the next issues
  bit   req_v[NREQ];
  logic [TAG_W-1:0] req_tag[NREQ];
  int   req_pct = 0, rdy_pct = 100, rr = 0, st = M_RUN;
  bit   rdy = 1'b1, flush = 1'b0, rand_flush = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit any_req();
    bit a = 1'b0;
    for (int i = 0; i < NREQ; i++) a |= req_v[i];
    return a;
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      ireq_valid[i] = req_v[i];
      ireq_tag[i*TAG_W +: TAG_W] = req_tag[i];
    end
    icalc_lowcontrast_en = lc_sched.exists(cyc) ? lc_sched[cyc] : 1'($urandom);
    rdy = ($urandom_range(99) < rdy_pct);
    ikp_ready = rdy;
    if (rand_flush) begin
      if (!flush && $urandom_range(99) < 3) flush = 1'b1;
      else if (flush && $urandom_range(99) < 15) flush = 1'b0;
    end
    iflush = flush;
  endtask

  // Reference model for one cycle: arbitration, credits, result timing, flush states.
  task automatic model_cycle();
    int out0;
    int g;
    int idx;
    logic [NREQ-1:0] er;
    bit ev;
    bit lc;
    out0 = pend.size();
    g = -1;
    er = '0;
    if (st == M_RUN && out0 < FDEPTH)
      for (int k = 0; k < NREQ; k++) begin
        idx = (rr + k) % NREQ;
        if (g < 0 && req_v[idx]) g = idx;
      end
    if (g >= 0) er[g] = 1'b1;
    check("oreq_ready", 32'(oreq_ready), 32'(er));
    ev = (out0 > 0) && (pend[0] <= cyc);
    check("okp_valid", 32'(okp_valid), 32'(ev));
    check("obusy", 32'(obusy), 32'(out0 > 0));
    check("oflush_done", 32'(oflush_done), 32'(st == M_DONE));
    if (ev && rdy) void'(pend.pop_front());
    if (g >= 0) begin
      lc = (lc_force.size() > 0) ? lc_force.pop_front() : 1'($urandom);
      lc_sched[cyc + LAT + 1] = lc;
      pend.push_back(cyc + LAT + 2);
      iss_q.push_back('{g, req_tag[g]});
      res_q.push_back('{g, req_tag[g], !lc});
      rr = (g + 1) % NREQ;
      req_v[g] = 1'b0;
    end
    case (st)
      M_RUN:   if (flush) st = M_FLUSH;
      M_FLUSH: if (out0 == 0) st = M_DONE;
      M_DONE:  st = flush ? M_WAIT : M_RUN;
      default: if (!flush) st = M_RUN;
    endcase
    for (int i = 0; i < NREQ; i++)
      if (!req_v[i] && $urandom_range(99) < req_pct) begin
        req_v[i] = 1'b1;
        req_tag[i] = TAG_W'($urandom);
      end
  endtask

  task automatic step();
    @(negedge iclk);
    model_cycle();
    @(posedge iclk);
    #1;
    cyc++;
    drive();
  endtask

  task automatic do_reset(input int n);
    irst_n = 1'b0;
    pend.delete(); iss_q.delete(); res_q.delete(); lc_sched.delete(); lc_force.delete();
    rr = 0; st = M_RUN; flush = 1'b0; rand_flush = 1'b0; req_pct = 0; rdy_pct = 100;
    for (int i = 0; i < NREQ; i++) begin req_v[i] = 1'b0; req_tag[i] = '0; end
    drive();
    repeat (n) begin
      @(negedge iclk);
      check("rst_oreq_ready", 32'(oreq_ready), 0);
      check("rst_ocalc_start", 32'(ocalc_start), 0);
      check("rst_ocalc_sel", 32'(ocalc_sel), 0);
      check("rst_ocalc_tag", 32'(ocalc_tag), 0);
      check("rst_okp_valid", 32'(okp_valid), 0);
      check("rst_okp_tag", 32'(okp_tag), 0);
      check("rst_okp_src", 32'(okp_src), 0);
      check("rst_okp_keep", 32'(okp_keep), 0);
      check("rst_oflush_done", 32'(oflush_done), 0);
      check("rst_obusy", 32'(obusy), 0);
`ifdef KP_CONTRAST_STATS_EN
      check("rst_okept_cnt", 32'(okept_cnt), 0);
      check("rst_orej_cnt", 32'(orej_cnt), 0);
`endif
      @(posedge iclk);
      #1;
      cyc++;
    end
    irst_n = 1'b1;
    drive();
  endtask

  task automatic drain();
    req_pct = 0;
    rdy_pct = 100;
    for (int k = 0; k < 200 && (any_req() || pend.size() > 0); k++) step();
    repeat (2) step();
  endtask

  task automatic single_request();
    lc_force.push_back(1'b0);
    req_v[1] = 1'b1;
    req_tag[1] = 20'h00A05;
    req_pct = 0;
    drive();
    repeat (10) step();
    check("single_result_popped", 32'(res_q.size()), 0);
  endtask

  // Scoreboard monitor: pops expectations whenever the DUT issues or delivers.
  initial begin
    iss_t ie;
    res_t re;
    forever begin
      @(negedge iclk);
      if (irst_n) begin
        if (ocalc_start) begin
          if (iss_q.size() == 0) check("issue_unexpected", 32'(ocalc_start), 0);
          else begin
            ie = iss_q.pop_front();
            check("ocalc_sel", 32'(ocalc_sel), 32'(ie.src));
            check("ocalc_tag", 32'(ocalc_tag), 32'(ie.tag));
          end
        end
        if (okp_valid && ikp_ready) begin
          if (res_q.size() == 0) check("result_unexpected", 32'(okp_valid), 0);
          else begin
            re = res_q.pop_front();
            check("okp_src", 32'(okp_src), 32'(re.src));
            check("okp_tag", 32'(okp_tag), 32'(re.tag));
            check("okp_keep", 32'(okp_keep), 32'(re.keep));
          end
        end
      end
    end
  end

  initial begin
    irst_n = 1'b0;
    do_reset(2);

    single_request();

    // All requesters continuously valid, downstream always ready.
    for (int i = 0; i < NREQ; i++) begin req_v[i] = 1'b1; req_tag[i] = TAG_W'($urandom); end
    req_pct = 100;
    drive();
    repeat (20) step();

    // Downstream stalled: credits run out, then resume one grant per pop.
    rdy_pct = 0;
    drive();
    repeat (16) step();
    rdy_pct = 100;
    drive();
    repeat (16) step();
    drain();

    // Datapath answers 1,0,1 on three issues.
    lc_force.push_back(1'b1); lc_force.push_back(1'b0); lc_force.push_back(1'b1);
    for (int i = 0; i < 3; i++) begin req_v[i] = 1'b1; req_tag[i] = TAG_W'($urandom); end
    drive();
    repeat (12) step();
    drain();

    // Flush with three in flight, requests pending during flush.
    for (int i = 0; i < 3; i++) begin req_v[i] = 1'b1; req_tag[i] = TAG_W'($urandom); end
    drive();
    repeat (3) step();
    flush = 1'b1;
    drive();
    step();
    for (int i = 0; i < NREQ; i++) begin req_v[i] = 1'b1; req_tag[i] = TAG_W'($urandom); end
    req_pct = 100;
    drive();
    repeat (15) step();
    flush = 1'b0;
    drive();
    repeat (8) step();

    // Random traffic, backpressure and flushes.
    req_pct = 50;
    rdy_pct = 70;
    rand_flush = 1'b1;
    drive();
    repeat (400) step();
    rand_flush = 1'b0;
    flush = 1'b0;
    drive();
    drain();

    // Reset in the middle of a burst, then a fresh request.
    for (int i = 0; i < NREQ; i++) begin req_v[i] = 1'b1; req_tag[i] = TAG_W'($urandom); end
    req_pct = 100;
    drive();
    repeat (6) step();
    do_reset(1);
    single_request();
    drain();

    check("issue_queue_empty", 32'(iss_q.size()), 0);
    check("result_queue_empty", 32'(res_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
